mem_port_arbiter: RTL and testbench

- Shares the single external program/data memory port between three requesters inside synth_top: core instruction fetch (index 0), core data load/store (index 1) and the I2C configuration loader (index 2).
- Sequences each access onto the memory bus. The bus is addr 10b, wdata 16b, write enable driving core_to_mem_enable_io, and rdata 16b.
- Returns read data to the requester that owns the access.
- Uses fixed priority with aging, so the config loader cannot be starved by the core.

---
 rtl/synth_pkg.sv | 12 +
 rtl/arb_age_prio.sv | 28 ++
 rtl/mem_port_arbiter.sv | 72 +++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: requester indices, arbiter state encoding and default bus widths
package synth_pkg;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA = 1;
  localparam int REQ_CFG = 2;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  function automatic logic [2:0] onehot3(input logic [1:0] i);
    return 3'b001 << i;
  endfunction
endpackage

// File: rtl/arb_age_prio.sv
// arb_age_prio: fixed-priority winner select (data > fetch > cfg) with aging promotion
module arb_age_prio
  import synth_pkg::*;
#(
  parameter int AGE_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [2:0] gnt,
  output logic [1:0] win,
  output logic       win_valid
);
  logic [7:0] age [3];
  logic [2:0] aged;
  for (genvar i = 0; i < 3; i++) begin : g_age
    assign aged[i] = req[i] && age[i] == 8'(AGE_LIMIT);
    always_ff @(posedge clk)
      age[i] <= rst || gnt[i] || !req[i] ? 8'd0 : aged[i] ? age[i] : age[i] + 8'd1;
  end
  // An aged requester pre-empts the fixed order; ties go to the lowest index.
  always_comb begin
    win = aged[REQ_FETCH] ? 2'(REQ_FETCH) : aged[REQ_DATA] ? 2'(REQ_DATA) :
          aged[REQ_CFG] ? 2'(REQ_CFG) : req[REQ_DATA] ? 2'(REQ_DATA) :
          req[REQ_FETCH] ? 2'(REQ_FETCH) : 2'(REQ_CFG);
    win_valid = |req;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch, data and config requesters,
// one access outstanding at a time, read data returned to the owning requester.
module mem_port_arbiter
  import synth_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = 1,
  parameter int AGE_LIMIT  = 15
) (
  input  logic                clk_io,
  input  logic                reset_io,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  state_t state, state_n;
  logic [1:0] owner, win;
  logic win_valid, owner_we;
  logic [2:0] lat;
  arb_age_prio #(.AGE_LIMIT(AGE_LIMIT)) u_arb (
    .clk(clk_io),
    .rst(reset_io),
    .req(req),
    .gnt(gnt),
    .win(win),
    .win_valid(win_valid)
  );
  // Grants happen only when the port is free: IDLE, or RETURN overlapping the next grant.
  always_comb begin
    gnt = !reset_io && win_valid && (state == IDLE || state == RETURN) ? onehot3(win) : 3'b000;
    state_n = state == ISSUE ? (owner_we ? IDLE : WAIT) :
              state == WAIT ? (lat == 3'd1 ? RETURN : WAIT) :
              |gnt ? ISSUE : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en && owner_we;
    rvalid = state == RETURN ? onehot3(owner) : 3'b000;
    busy = state != IDLE;
  end
  always_ff @(posedge clk_io)
    state <= reset_io ? IDLE : state_n;
  always_ff @(posedge clk_io) begin
    if (reset_io) begin
      owner <= '0;
      owner_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      lat <= '0;
      rdata <= '0;
    end else begin
      if (|gnt) begin
        owner <= win;
        owner_we <= we[win];
        mem_addr <= addr[win*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[win*DATA_W +: DATA_W];
      end
      if (state == ISSUE) lat <= 3'(RD_LATENCY);
      else if (state == WAIT) lat <= lat - 3'd1;
      if (state == WAIT && lat == 3'd1) rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; u_dut (latency 1, age limit 4) carries all traffic,
// u_dut3 (latency 3) shares the stimulus and is checked on the single-read scenario.
module tb_mem_port_arbiter;
  import synth_pkg::*;
  localparam int AW = 10, DW = 16;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} acc_t;
  typedef struct packed {logic [2:0] owner; logic [DW-1:0] data;} ret_t;
  logic clk = 0, rst = 0;
  logic [2:0] req = 0, we = 0;
  logic [3*AW-1:0] addr = 0;
  logic [3*DW-1:0] wdata = 0;
  logic [2:0] gnt, rvalid, gnt3, rvalid3;
  logic [DW-1:0] rdata, rdata3, mem_wdata, mem_wdata3, mem_rdata, mem_rdata3;
  logic mem_en, mem_we, busy, mem_en3, mem_we3, busy3;
  logic [AW-1:0] mem_addr, mem_addr3;
  logic [DW-1:0] pipe3 [3];
  acc_t acc_q[$], mon_a;
  ret_t ret_q[$], mon_r;
  int n_chk = 0, n_fail = 0, cyc = 0;

  mem_port_arbiter #(.RD_LATENCY(1), .AGE_LIMIT(4)) u_dut (
    .clk_io(clk), .reset_io(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_port_arbiter #(.RD_LATENCY(3), .AGE_LIMIT(15)) u_dut3 (
    .clk_io(clk), .reset_io(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a == 10'h00C ? 16'h4F20 : {a[5:0], a} ^ 16'h3C3C;
  endfunction

  // read-only memory models: one registered stage for u_dut, three for u_dut3
  always @(posedge clk) begin
    mem_rdata <= mem_val(mem_addr);
    pipe3[0] <= mem_val(mem_addr3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata3 = pipe3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("mem_we only with mem_en", {31'b0, mem_we & ~mem_en}, 0);
    if (mem_en) begin
      if (acc_q.size() == 0) check("spurious mem_en", {31'b0, mem_en}, 0);
      else begin
        mon_a = acc_q.pop_front();
        check("sb mem_we", {31'b0, mem_we}, {31'b0, mon_a.we});
        check("sb mem_addr", {22'b0, mem_addr}, {22'b0, mon_a.addr});
        if (mon_a.we) check("sb mem_wdata", {16'b0, mem_wdata}, {16'b0, mon_a.wdata});
      end
    end
    if (|rvalid) begin
      if (ret_q.size() == 0) check("spurious rvalid", {29'b0, rvalid}, 0);
      else begin
        mon_r = ret_q.pop_front();
        check("sb rvalid owner", {29'b0, rvalid}, {29'b0, mon_r.owner});
        check("sb rdata", {16'b0, rdata}, {16'b0, mon_r.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int gc);
    set_req(i, w, a, d);
    gc = -1;
    for (int n = 0; n < 100 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt[i]) gc = cyc;
      tick();
    end
    req[i] = 1'b0;
    check($sformatf("req%0d granted in time", i), {31'b0, gc >= 0}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    @(negedge clk);
    check("rst gnt", {29'b0, gnt}, 0);
    check("rst rvalid", {29'b0, rvalid}, 0);
    check("rst rdata", {16'b0, rdata}, 0);
    check("rst mem_en", {31'b0, mem_en}, 0);
    check("rst mem_we", {31'b0, mem_we}, 0);
    check("rst mem_addr", {22'b0, mem_addr}, 0);
    check("rst mem_wdata", {16'b0, mem_wdata}, 0);
    check("rst busy", {31'b0, busy}, 0);
    check("rst dut3 busy/en", {30'b0, busy3, mem_en3}, 0);
    check("rst dut3 rvalid", {29'b0, rvalid3}, 0);
    check("rst dut3 rdata", {16'b0, rdata3}, 0);
    check("rst dut3 mem_wdata", {16'b0, mem_wdata3}, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int g0, g1, g2;
    logic [2:0] exp_s [8];
    exp_s = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000};
    do_reset();
    // single config write
    tick();
    acc_q.push_back({1'b1, 10'h3FF, 16'hBEEF});
    set_req(2, 1'b1, 10'h3FF, 16'hBEEF);
    @(negedge clk);
    check("wr gnt", {29'b0, gnt}, 3'b100);
    tick();
    req[2] = 1'b0;
    @(negedge clk);
    check("wr mem_en/we", {30'b0, mem_en, mem_we}, 2'b11);
    check("wr mem_addr", {22'b0, mem_addr}, 10'h3FF);
    check("wr mem_wdata", {16'b0, mem_wdata}, 16'hBEEF);
    tick();
    @(negedge clk);
    check("wr busy after", {31'b0, busy}, 0);
    // single fetch read on both latencies
    tick();
    acc_q.push_back({1'b0, 10'h00C, 16'h0});
    ret_q.push_back({3'b001, mem_val(10'h00C)});
    set_req(0, 1'b0, 10'h00C, 16'h0);
    @(negedge clk);
    check("rd gnt", {29'b0, gnt}, 3'b001);
    check("rd gnt lat3", {29'b0, gnt3}, 3'b001);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("rd mem_en/we", {30'b0, mem_en, mem_we}, 2'b10);
    check("rd lat3 mem_we", {31'b0, mem_we3}, 0);
    tick();
    @(negedge clk);
    check("rd rvalid early", {29'b0, rvalid}, 0);
    tick();
    @(negedge clk);
    check("rd rvalid N+3", {29'b0, rvalid}, 3'b001);
    check("rd rdata N+3", {16'b0, rdata}, 16'h4F20);
    check("rd lat3 rvalid N+3", {29'b0, rvalid3}, 0);
    tick();
    @(negedge clk);
    check("rd rvalid pulse", {29'b0, rvalid}, 0);
    check("rd rdata held", {16'b0, rdata}, 16'h4F20);
    check("rd lat3 rvalid N+4", {29'b0, rvalid3}, 0);
    tick();
    @(negedge clk);
    check("rd lat3 rvalid N+5", {29'b0, rvalid3}, 3'b001);
    check("rd lat3 rdata N+5", {16'b0, rdata3}, 16'h4F20);
    tick();
    // reset in the middle of a read drops it
    acc_q.push_back({1'b0, 10'h005, 16'h0});
    set_req(0, 1'b0, 10'h005, 16'h0);
    @(negedge clk);
    check("rstmid gnt", {29'b0, gnt}, 3'b001);
    tick();
    req[0] = 1'b0;
    tick();
    @(negedge clk);
    check("rstmid busy in wait", {31'b0, busy}, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid no rvalid", {29'b0, rvalid}, 0);
      tick();
    end
    // simultaneous requests: data, then fetch, then cfg
    acc_q.push_back({1'b0, 10'h020, 16'h0});
    acc_q.push_back({1'b0, 10'h010, 16'h0});
    acc_q.push_back({1'b1, 10'h030, 16'h1234});
    ret_q.push_back({3'b010, mem_val(10'h020)});
    ret_q.push_back({3'b001, mem_val(10'h010)});
    fork
      do_req(0, 1'b0, 10'h010, 16'h0, g0);
      do_req(1, 1'b0, 10'h020, 16'h0, g1);
      do_req(2, 1'b1, 10'h030, 16'h1234, g2);
    join
    check("sim data->fetch gap", g0 - g1, 3);
    check("sim fetch->cfg gap", g2 - g0, 3);
    repeat (3) tick();
    // starvation: everyone requests writes continuously, aging kicks in at 4
    do_reset();
    acc_q.push_back({1'b1, 10'h101, 16'hD001});
    acc_q.push_back({1'b1, 10'h101, 16'hD001});
    acc_q.push_back({1'b1, 10'h100, 16'hF001});
    acc_q.push_back({1'b1, 10'h102, 16'hC001});
    set_req(0, 1'b1, 10'h100, 16'hF001);
    set_req(1, 1'b1, 10'h101, 16'hD001);
    set_req(2, 1'b1, 10'h102, 16'hC001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("starve gnt c%0d", k), {29'b0, gnt}, {29'b0, exp_s[k]});
      if (k == 4 || k == 6) check($sformatf("starve cfg age c%0d", k), {24'b0, u_dut.u_arb.age[2]}, 4);
      if (k == 7) check("starve cfg age cleared", {24'b0, u_dut.u_arb.age[2]}, 0);
      tick();
      if (k == 6) req[2] = 1'b0;
    end
    req = '0;
    repeat (3) tick();
    // withdrawal: cfg pulses req for one cycle while the port is busy
    acc_q.push_back({1'b0, 10'h040, 16'h0});
    ret_q.push_back({3'b010, mem_val(10'h040)});
    set_req(1, 1'b0, 10'h040, 16'h0);
    @(negedge clk);
    check("wd data gnt", {29'b0, gnt}, 3'b010);
    tick();
    req[1] = 1'b0;
    set_req(2, 1'b1, 10'h3A0, 16'h5555);
    @(negedge clk);
    check("wd no gnt while busy", {29'b0, gnt}, 0);
    check("wd busy", {31'b0, busy}, 1);
    tick();
    req[2] = 1'b0;
    @(negedge clk);
    check("wd cfg age 1", {24'b0, u_dut.u_arb.age[2]}, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wd no cfg gnt", {31'b0, gnt[2]}, 0);
      check("wd cfg age 0", {24'b0, u_dut.u_arb.age[2]}, 0);
      tick();
    end
    check("acc queue drained", acc_q.size(), 0);
    check("ret queue drained", ret_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
